// File: rtl/dmem_responder.sv
// dmem_responder: load/store target for the executor, word RAM with fixed read latency
// Ports: clk, rst (sync, active-high); mem_addr_in/mem_wdata_in/mem_read_in/mem_write_in
// request side; mem_wstrb_in byte enables (only with DMEM_BYTE_STROBE_EN); mem_rdata/mem_rvalid
// response; mem_busy stall; mem_err one-cycle rejection pulse.
// Build option: DMEM_BYTE_STROBE_EN enables per-byte write strobes.
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_wdata_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  mem_wstrb_in,
`endif
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_busy,
  output logic        mem_err
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [2:0] cnt;
  logic [31:0] ram [DEPTH];
  logic [ADDR_W-1:0] idx, addr_q;
  logic [3:0] strb;
  logic idle, misal, err_c, acc_rd, acc_wr;
  logic unused_addr;
  assign unused_addr = ^mem_addr_in[31:ADDR_W+2];
`ifdef DMEM_BYTE_STROBE_EN
  assign strb = mem_wstrb_in;
`else
  assign strb = 4'hF;
`endif
  always_comb begin
    idx = mem_addr_in[ADDR_W+1:2];
    idle = state == IDLE;
    misal = |mem_addr_in[1:0];
    err_c = idle & (mem_read_in | mem_write_in) & (misal | (mem_read_in & mem_write_in));
    acc_rd = idle & mem_read_in & ~mem_write_in & ~misal;
    acc_wr = idle & mem_write_in & ~mem_read_in & ~misal;
  end
  always_ff @(posedge clk)
    if (acc_wr && !rst)
      for (int k = 0; k < 4; k++)
        if (strb[k]) ram[idx][8*k +: 8] <= mem_wdata_in[8*k +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      addr_q <= '0;
      mem_rdata <= 32'd0;
      mem_rvalid <= 1'b0;
      mem_busy <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      mem_err <= err_c;
      if (state == IDLE) begin
        if (acc_rd && READ_LATENCY == 1) begin
          mem_rdata <= ram[idx];
          mem_rvalid <= 1'b1;
        end else if (acc_rd) begin
          state <= WAIT;
          mem_busy <= 1'b1;
          cnt <= CNT_INIT;
          addr_q <= idx;
        end
      end else if (cnt == 3'd0) begin
        mem_rdata <= ram[addr_q];
        mem_rvalid <= 1'b1;
        mem_busy <= 1'b0;
        state <= IDLE;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end
  end
endmodule
